// File: rtl/la_vdemux2s.sv
// Valid/ready 1:2 demux: each input word is steered by one-hot selects into one of two
// independent 2-entry FIFOs; an invalid select is consumed and raises a sticky error flag.
module la_vdemux2s #(
    parameter N    = 1,
    parameter PROP = "DEFAULT"
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sel1,
    input  logic         sel0,
    input  logic [N-1:0] in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out0,
    output logic [N-1:0] out1,
    output logic         out0_valid,
    output logic         out1_valid,
    input  logic         out0_ready,
    input  logic         out1_ready,
    output logic         err
);

    // PROP is a library cell hint only and changes nothing in the logic.
    if ($bits(PROP) == 0) begin : g_no_prop
    end

    logic [N-1:0] r_mem [2][2];
    logic [1:0]   r_wp;
    logic [1:0]   r_rp;
    logic [1:0]   r_cnt [2];
    logic         r_err;

    logic         w_sel_ch0;
    logic         w_sel_ch1;
    logic         w_sel_bad;
    logic         w_accept;
    logic [1:0]   w_full;
    logic [1:0]   w_push;
    logic [1:0]   w_pop;

    assign w_sel_ch0 = sel0 & ~sel1;
    assign w_sel_ch1 = sel1 & ~sel0;
    assign w_sel_bad = (sel0 == sel1);

    assign w_full[0] = (r_cnt[0] == 2'd2);
    assign w_full[1] = (r_cnt[1] == 2'd2);

    // Readiness looks only at registered occupancy, so a full channel refuses even if it pops.
    assign in_ready = (w_sel_ch0 & ~w_full[0]) | (w_sel_ch1 & ~w_full[1]) | w_sel_bad;
    assign w_accept = in_valid & in_ready;

    assign w_push[0] = w_accept & w_sel_ch0;
    assign w_push[1] = w_accept & w_sel_ch1;
    assign w_pop[0]  = (r_cnt[0] != 2'd0) & out0_ready;
    assign w_pop[1]  = (r_cnt[1] != 2'd0) & out1_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                r_mem[k][0] <= '0;
                r_mem[k][1] <= '0;
                r_cnt[k]    <= 2'd0;
            end
            r_wp  <= 2'b00;
            r_rp  <= 2'b00;
            r_err <= 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (w_push[k]) begin
                    r_mem[k][r_wp[k]] <= in;
                    r_wp[k]           <= ~r_wp[k];
                end
                if (w_pop[k]) begin
                    r_rp[k] <= ~r_rp[k];
                end
                r_cnt[k] <= r_cnt[k] + {1'b0, w_push[k]} - {1'b0, w_pop[k]};
            end
            if (w_accept & w_sel_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign out0       = r_mem[0][r_rp[0]];
    assign out1       = r_mem[1][r_rp[1]];
    assign out0_valid = (r_cnt[0] != 2'd0);
    assign out1_valid = (r_cnt[1] != 2'd0);
    assign err        = r_err;

endmodule

// File: tb/tb_la_vdemux2s.sv
// Bench for la_vdemux2s (N=8): directed scenarios plus random traffic, checked against
// per-channel queue models and a sticky error flag.
module tb_la_vdemux2s;

    logic       clk;
    logic       reset;
    logic       sel0;
    logic       sel1;
    logic [7:0] din;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out0;
    logic [7:0] out1;
    logic       out0_valid;
    logic       out1_valid;
    logic       out0_ready;
    logic       out1_ready;
    logic       err;

    int tests = 0;
    int fails = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         m_err;

    la_vdemux2s #(.N(8), .PROP("DEFAULT")) dut (
        .clk        (clk),
        .reset      (reset),
        .sel1       (sel1),
        .sel0       (sel0),
        .in         (din),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0       (out0),
        .out1       (out1),
        .out0_valid (out0_valid),
        .out1_valid (out1_valid),
        .out0_ready (out0_ready),
        .out1_ready (out1_ready),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the queue model.
    task automatic chk_outputs(input string tag);
        chk({tag, ":out0_valid"}, 32'(out0_valid), 32'(q0.size() != 0));
        chk({tag, ":out1_valid"}, 32'(out1_valid), 32'(q1.size() != 0));
        if (q0.size() != 0) chk({tag, ":out0"}, 32'(out0), 32'(q0[0]));
        if (q1.size() != 0) chk({tag, ":out1"}, 32'(out1), 32'(q1[0]));
        chk({tag, ":err"}, 32'(err), 32'(m_err));
    endtask

    // One clock cycle: called just after a falling edge, returns just after the next one.
    task automatic cyc(input string tag, input bit s0, input bit s1, input logic [7:0] d,
                       input bit v, input bit r0, input bit r1);
        bit exp_rdy;
        bit acc;
        sel0 = s0; sel1 = s1; din = d; in_valid = v; out0_ready = r0; out1_ready = r1;
        #1;
        exp_rdy = (s0 && !s1 && q0.size() < 2) || (s1 && !s0 && q1.size() < 2) || (s0 == s1);
        chk({tag, ":in_ready"}, 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        acc = v && exp_rdy;
        if (r0 && q0.size() != 0) void'(q0.pop_front());
        if (r1 && q1.size() != 0) void'(q1.pop_front());
        if (acc) begin
            if (s0 && !s1)      q0.push_back(d);
            else if (s1 && !s0) q1.push_back(d);
            else                m_err = 1'b1;
        end
        @(negedge clk);
        chk_outputs(tag);
    endtask

    initial begin
        reset = 1'b1; sel0 = 1'b1; sel1 = 1'b0; din = 8'h00; in_valid = 1'b0;
        out0_ready = 1'b0; out1_ready = 1'b0; m_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hold:out0_valid", 32'(out0_valid), 32'd0);
        chk("rst_hold:err", 32'(err), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst:out0_valid", 32'(out0_valid), 32'd0);
        chk("post_rst:out1_valid", 32'(out1_valid), 32'd0);
        chk("post_rst:err", 32'(err), 32'd0);
        chk("post_rst:out0", 32'(out0), 32'h00);
        chk("post_rst:in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Channel 0 fills, refuses a third word even while popping, then takes it.
        cyc("c0_push11", 1, 0, 8'h11, 1, 0, 0);
        cyc("c0_push22", 1, 0, 8'h22, 1, 0, 0);
        cyc("c0_full", 1, 0, 8'h33, 1, 0, 0);
        chk("c0_full:in_ready_low", 32'(in_ready), 32'd0);
        cyc("c0_pop11", 1, 0, 8'h33, 1, 1, 0);
        chk("c0_pop11:head22", 32'(out0), 32'h22);
        cyc("c0_pop22_push33", 1, 0, 8'h33, 1, 1, 0);
        chk("c0_push33:head33", 32'(out0), 32'h33);
        cyc("c0_drain", 1, 0, 8'h00, 0, 1, 0);

        // Channel 0 stalled full must not block channel 1.
        cyc("fill_a", 1, 0, 8'hC1, 1, 0, 0);
        cyc("fill_b", 1, 0, 8'hC2, 1, 0, 0);
        cyc("c1_pushA5", 0, 1, 8'hA5, 1, 0, 0);
        chk("c1_pushA5:out1", 32'(out1), 32'hA5);
        chk("c1_pushA5:out0_held", 32'(out0), 32'hC1);
        cyc("drain_a", 0, 0, 8'h00, 0, 1, 1);
        cyc("drain_b", 0, 0, 8'h00, 0, 1, 1);

        // Invalid selects are consumed and latch the error flag.
        cyc("bad_both1", 1, 1, 8'h5A, 1, 0, 0);
        chk("bad_both1:err_set", 32'(err), 32'd1);
        cyc("bad_both0", 0, 0, 8'h5A, 1, 0, 0);
        chk("bad_both0:err_sticky", 32'(err), 32'd1);

        // Push and pop together at count 1.
        cyc("c1_push01", 0, 1, 8'h01, 1, 0, 0);
        cyc("c1_swap02", 0, 1, 8'h02, 1, 0, 1);
        chk("c1_swap02:out1", 32'(out1), 32'h02);
        cyc("c1_last_pop", 0, 1, 8'h00, 0, 0, 1);
        chk("c1_last_pop:empty", 32'(out1_valid), 32'd0);

        for (int i = 0; i < 400; i++) begin
            bit s0, s1;
            s0 = 1'($urandom_range(0, 1));
            s1 = ($urandom_range(0, 9) < 2) ? s0 : ~s0;
            cyc("rand", s0, s1, 8'($urandom), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
        end

        // Fill both channels, then assert reset between edges.
        cyc("pre_rst_a", 1, 0, 8'hE0, 1, 0, 0);
        cyc("pre_rst_b", 1, 0, 8'hE1, 1, 0, 0);
        cyc("pre_rst_c", 0, 1, 8'hE2, 1, 0, 0);
        cyc("pre_rst_d", 0, 1, 8'hE3, 1, 0, 0);
        cyc("pre_rst_e", 1, 1, 8'hE4, 1, 0, 0);
        chk("pre_rst:err", 32'(err), 32'd1);
        sel0 = 1'b1; sel1 = 1'b0; in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async_rst:out0_valid", 32'(out0_valid), 32'd0);
        chk("async_rst:out1_valid", 32'(out1_valid), 32'd0);
        chk("async_rst:err", 32'(err), 32'd0);
        chk("async_rst:out0", 32'(out0), 32'h00);
        chk("async_rst:out1", 32'(out1), 32'h00);
        chk("async_rst:in_ready", 32'(in_ready), 32'd1);
        q0.delete(); q1.delete(); m_err = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        cyc("after_rst_push", 0, 1, 8'h77, 1, 0, 0);
        cyc("after_rst_pop", 0, 0, 8'h00, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/la_vdemux2s.md
LA_VDEMUX2S -- requirements
Module: la_vdemux2s

Interface
- REQ-001 SHALL have parameter N, default 1, the data width in bits.
- REQ-002 SHALL have parameter PROP, default "DEFAULT", the cell property string; it SHALL have no functional effect.
- REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
- REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
- REQ-005 SHALL have port sel1, input, 1 bit: one-hot select for output channel 1, sampled when a transfer is accepted.
- REQ-006 SHALL have port sel0, input, 1 bit: one-hot select for output channel 0, sampled when a transfer is accepted.
- REQ-007 SHALL have port in, input, N bits: input data word.
- REQ-008 SHALL have port in_valid, input, 1 bit: the input word and selects are valid.
- REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts the input word this cycle.
- REQ-010 SHALL have ports out0 and out1, output, N bits each: the head word of channel 0 and channel 1.
- REQ-011 SHALL have ports out0_valid and out1_valid, output, 1 bit each: the channel holds at least one word.
- REQ-012 SHALL have ports out0_ready and out1_ready, input, 1 bit each: the downstream consumer takes the head word.
- REQ-013 SHALL have port err, output, 1 bit: sticky flag set when an invalid select is accepted.

Function
- REQ-014 An input transfer SHALL occur when in_valid=1 and in_ready=1 in the same cycle.
- REQ-015 Each channel k SHALL own a 2-entry FIFO buffer with an occupancy count of 0..2; fullk SHALL mean the count equals 2.
- REQ-016 in_ready SHALL equal (sel0 & ~sel1 & ~full0) | (sel1 & ~sel0 & ~full1) | (sel0 == sel1).
- REQ-017 in_ready SHALL depend only on the selects and registered occupancy, never combinationally on out0_ready or out1_ready.
- REQ-018 A full channel SHALL refuse a push even if it pops in the same cycle.
- REQ-019 An accepted transfer with sel0=1, sel1=0 SHALL push in into channel 0; with sel1=1, sel0=0 it SHALL push into channel 1.
- REQ-020 An accepted transfer with sel0 == sel1 (both 0 or both 1) SHALL push into neither channel, SHALL set err to 1 on the next edge, and SHALL be consumed so that the input never deadlocks.
- REQ-021 Latency from an accepted push into an empty channel to outk_valid=1 with outk equal to the pushed word SHALL be one clock cycle.
- REQ-022 outk_valid SHALL be 1 exactly when the channel k count is nonzero; outk SHALL present the oldest stored word.
- REQ-023 A pop SHALL occur when outk_valid=1 and outk_ready=1, and SHALL remove the head word on that edge.
- REQ-024 outk_ready while outk_valid=0 SHALL have no effect.
- REQ-025 A simultaneous push and pop on one channel with count 1 SHALL leave the count at 1 with the new word at the head on the next cycle.
- REQ-026 Each channel SHALL preserve arrival order; the two channels SHALL be fully independent, and a stalled channel SHALL NOT block transfers selected to the other channel.
- REQ-027 outk and the held words SHALL remain stable while outk_valid=1 and outk_ready=0.
- REQ-028 Read and write pointers SHALL be 1 bit each and SHALL wrap modulo 2.
- REQ-029 err SHALL clear only on reset.

Reset
- REQ-030 While reset=1, regardless of clk, the block SHALL force out0_valid=0, out1_valid=0, err=0, all counts and pointers to 0, and out0 and out1 to all zeros.
- REQ-031 Assertion of reset mid-operation SHALL discard all buffered words without any pop handshake.
- REQ-032 The first transfer after reset deassertion SHALL be acceptable on the first rising clk edge.

Verification
- REQ-033 Apply reset=1, then release it, with N=8 -> out0_valid=0, out1_valid=0, err=0, out0=0x00, in_ready=1 for sel0=1, sel1=0.
- REQ-034 With out0_ready=0, push 0x11, 0x22, then 0x33 to channel 0 -> in_ready=0 after two pushes; raising out0_ready pops 0x11 then 0x22; 0x33 is accepted after a slot frees.
- REQ-035 With channel 0 full and out0_ready=0, push 0xA5 to channel 1 -> accepted, out1=0xA5 and out1_valid=1 the next cycle, and channel 0 is unchanged.
- REQ-036 Push 0x5A with sel0=1, sel1=1, then with sel0=0, sel1=0 -> both accepted, neither valid rises, err=1 after the first and remains 1.
- REQ-037 With channel 1 at count 1 holding 0x01, pulse out1_ready=1 while pushing 0x02 in the same cycle -> the count stays 1 and out1=0x02.
- REQ-038 Assert reset with both channels full and err=1 -> all valids and err go to 0 immediately, without waiting for a clock edge.
